// File: rtl/riscv_defs.sv
// Shared RV32I definitions for the instruction encoder: formats, opcodes,
// error codes, FSM encoding and a signed-range helper.
package riscv_defs;

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  localparam logic [6:0] OP     = 7'h33;
  localparam logic [6:0] OP_IMM = 7'h13;
  localparam logic [6:0] LOAD   = 7'h03;
  localparam logic [6:0] STORE  = 7'h23;
  localparam logic [6:0] BRANCH = 7'h63;
  localparam logic [6:0] JAL    = 7'h6F;
  localparam logic [6:0] JALR   = 7'h67;
  localparam logic [6:0] LUI    = 7'h37;
  localparam logic [6:0] AUIPC  = 7'h17;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_RANGE   = 2'b01;
  localparam logic [1:0] ERR_ALIGN   = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL = 2'b11;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RUN   = 3'd1;
  localparam logic [2:0] ST_WRITE = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
  localparam logic [2:0] ST_ERROR = 3'd4;

  // A value fits in 'bits' signed bits when everything above the sign bit
  // replicates it, i.e. the arithmetic shift leaves all zeros or all ones.
  function automatic logic fits_signed(input logic [31:0] value, input int bits);
    logic signed [31:0] upper;
    upper = $signed(value) >>> (bits - 1);
    return (upper == '0) || (upper == '1);
  endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational RV32I packer with immediate range and alignment checks.
module instr_pack
  import riscv_defs::*;
(
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  func3,
  input  logic [6:0]  func7,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        bad,
  output logic [1:0]  code
);

  logic range_bad;
  logic align_bad;
  logic illegal;

  always_comb begin
    word      = '0;
    range_bad = 1'b0;
    align_bad = 1'b0;
    illegal   = 1'b0;
    case (fmt)
      FMT_R: word = {func7, rs2, rs1, func3, rd, opcode};
      FMT_I: begin
        word      = {imm[11:0], rs1, func3, rd, opcode};
        range_bad = !fits_signed(imm, 12);
      end
      FMT_S: begin
        word      = {imm[11:5], rs2, rs1, func3, imm[4:0], opcode};
        range_bad = !fits_signed(imm, 12);
      end
      FMT_B: begin
        word      = {imm[12], imm[10:5], rs2, rs1, func3, imm[4:1], imm[11], opcode};
        range_bad = !fits_signed(imm, 13);
        align_bad = imm[0];
      end
      FMT_U: begin
        word      = {imm[31:12], rd, opcode};
        align_bad = |imm[11:0];
      end
      FMT_J: begin
        word      = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        range_bad = !fits_signed(imm, 21);
        align_bad = imm[0];
      end
      default: illegal = 1'b1;
    endcase
  end

  // Illegal format outranks range, which outranks alignment.
  assign code = illegal   ? ERR_ILLEGAL :
                range_bad ? ERR_RANGE   :
                align_bad ? ERR_ALIGN   : ERR_NONE;
  assign bad  = illegal | range_bad | align_bad;

endmodule

// File: rtl/instr_encoder.sv
// Accepts decoded instruction bundles, packs them into RV32I words and writes
// them sequentially into instruction memory over a write/ack handshake.
module instr_encoder
  import riscv_defs::*;
#(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_fmt,
  input  logic [6:0]        in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_func3,
  input  logic [6:0]        in_func7,
  input  logic [31:0]       in_imm,
  input  logic              in_last,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   instr_count
);

  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W:0]   CAPACITY = (ADDR_W + 1)'(1) << ADDR_W;

  logic [2:0]  state;
  logic        last_q;
  logic [31:0] packed_word;
  logic        pack_bad;
  logic [1:0]  pack_code;
  logic        full;

  instr_pack u_pack (
    .fmt    (in_fmt),
    .opcode (in_opcode),
    .rd     (in_rd),
    .rs1    (in_rs1),
    .rs2    (in_rs2),
    .func3  (in_func3),
    .func7  (in_func7),
    .imm    (in_imm),
    .word   (packed_word),
    .bad    (pack_bad),
    .code   (pack_code)
  );

  assign full     = (instr_count == CAPACITY);
  assign in_ready = (state == ST_RUN);
  assign mem_wen  = (state == ST_WRITE);
  assign done     = (state == ST_DONE);
  assign err      = (state == ST_ERROR);

  // start overrides everything, including a coincident accept or ack.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      last_q      <= 1'b0;
      mem_wdata   <= '0;
      mem_addr    <= BASE;
      instr_count <= '0;
      err_code    <= ERR_NONE;
    end else if (start) begin
      state       <= ST_RUN;
      last_q      <= 1'b0;
      mem_addr    <= BASE;
      instr_count <= '0;
      err_code    <= ERR_NONE;
    end else begin
      case (state)
        ST_RUN: begin
          if (in_valid) begin
            if (full) begin
              state    <= ST_ERROR;
              err_code <= ERR_ILLEGAL;
            end else if (pack_bad) begin
              state    <= ST_ERROR;
              err_code <= pack_code;
            end else begin
              state     <= ST_WRITE;
              mem_wdata <= packed_word;
              last_q    <= in_last;
            end
          end
        end
        ST_WRITE: begin
          if (mem_ack) begin
            mem_addr    <= mem_addr + ADDR_W'(1);
            instr_count <= instr_count + (ADDR_W + 1)'(1);
            state       <= last_q ? ST_DONE : ST_RUN;
          end
        end
        ST_IDLE, ST_DONE, ST_ERROR: state <= state;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed program scenarios plus
// randomized bundles compared against an arithmetic reference encoder.
module tb_instr_encoder;
  import riscv_defs::*;

  logic        clk = 1'b0;
  logic        reset, start, in_valid, in_last, mem_ack;
  logic [2:0]  in_fmt, in_func3;
  logic [6:0]  in_opcode, in_func7;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm;

  logic        in_ready, mem_wen, done, err;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [1:0]  err_code;
  logic [10:0] instr_count;

  logic        s_in_ready, s_mem_wen, s_done, s_err;
  logic [1:0]  s_mem_addr;
  logic [31:0] s_mem_wdata;
  logic [1:0]  s_err_code;
  logic [2:0]  s_instr_count;

  always #5 clk = ~clk;

  instr_encoder dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_func3(in_func3), .in_func7(in_func7), .in_imm(in_imm), .in_last(in_last),
    .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .done(done), .err(err), .err_code(err_code), .instr_count(instr_count)
  );

  // Tiny memory (4 words) used for the memory-full scenario.
  instr_encoder #(.ADDR_W(2)) dut_small (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_func3(in_func3), .in_func7(in_func7), .in_imm(in_imm), .in_last(in_last),
    .mem_wen(s_mem_wen), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata), .mem_ack(mem_ack),
    .done(s_done), .err(s_err), .err_code(s_err_code), .instr_count(s_instr_count)
  );

  bit          use_small = 1'b0;
  int          vectors = 0;
  int          miscompares = 0;
  int          model_count = 0;

  logic        o_ready, o_wen, o_done, o_err;
  logic [9:0]  o_addr;
  logic [31:0] o_wdata;
  logic [1:0]  o_code;
  logic [10:0] o_count;

  assign o_ready = use_small ? s_in_ready : in_ready;
  assign o_wen   = use_small ? s_mem_wen : mem_wen;
  assign o_done  = use_small ? s_done : done;
  assign o_err   = use_small ? s_err : err;
  assign o_addr  = use_small ? {8'b0, s_mem_addr} : mem_addr;
  assign o_wdata = use_small ? s_mem_wdata : mem_wdata;
  assign o_code  = use_small ? s_err_code : err_code;
  assign o_count = use_small ? {8'b0, s_instr_count} : instr_count;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference encoder built from shifts and masks over the field values.
  function automatic void ref_encode(input logic [2:0] fmt, input logic [6:0] op,
                                     input logic [4:0] rd, input logic [4:0] rs1,
                                     input logic [4:0] rs2, input logic [2:0] f3,
                                     input logic [6:0] f7, input logic [31:0] imm,
                                     output logic [31:0] word, output logic [1:0] code);
    logic [31:0] o, d, a, b, f, g, m;
    longint s;
    bit rng, aln;
    o = 32'(op); d = 32'(rd); a = 32'(rs1); b = 32'(rs2); f = 32'(f3); g = 32'(f7); m = imm;
    s = longint'($signed(imm));
    rng = 0; aln = 0; word = 0;
    case (fmt)
      3'd0: word = (g << 25) | (b << 20) | (a << 15) | (f << 12) | (d << 7) | o;
      3'd1: begin
        word = ((m & 32'hFFF) << 20) | (a << 15) | (f << 12) | (d << 7) | o;
        rng = (s < -2048) || (s > 2047);
      end
      3'd2: begin
        word = (((m >> 5) & 32'h7F) << 25) | (b << 20) | (a << 15) | (f << 12)
             | ((m & 32'h1F) << 7) | o;
        rng = (s < -2048) || (s > 2047);
      end
      3'd3: begin
        word = (((m >> 12) & 32'h1) << 31) | (((m >> 5) & 32'h3F) << 25) | (b << 20)
             | (a << 15) | (f << 12) | (((m >> 1) & 32'hF) << 8)
             | (((m >> 11) & 32'h1) << 7) | o;
        rng = (s < -4096) || (s > 4095);
        aln = (s % 2) != 0;
      end
      3'd4: begin
        word = (m & 32'hFFFFF000) | (d << 7) | o;
        aln = (m % 4096) != 0;
      end
      3'd5: begin
        word = (((m >> 20) & 32'h1) << 31) | (((m >> 1) & 32'h3FF) << 21)
             | (((m >> 11) & 32'h1) << 20) | (((m >> 12) & 32'hFF) << 12) | (d << 7) | o;
        rng = (s < -1048576) || (s > 1048575);
        aln = (s % 2) != 0;
      end
      default: ;
    endcase
    if (fmt > 3'd5) code = 2'b11;
    else if (rng)   code = 2'b01;
    else if (aln)   code = 2'b10;
    else            code = 2'b00;
  endfunction

  task automatic do_start;
    start = 1'b1;
    tick();
    start = 1'b0;
    model_count = 0;
    check_output("start_ready", o_ready, 1);
    check_output("start_err", o_err, 0);
    check_output("start_code", o_code, 0);
    check_output("start_count", o_count, 0);
  endtask

  task automatic apply_stimulus(input logic [2:0] fmt, input logic [6:0] op,
                                input logic [4:0] rd, input logic [4:0] rs1,
                                input logic [4:0] rs2, input logic [2:0] f3,
                                input logic [6:0] f7, input logic [31:0] imm,
                                input logic last, input int ack_delay);
    logic [31:0] exp_word;
    logic [1:0]  exp_code;
    int cap;
    int n;
    cap = use_small ? 4 : 1024;
    ref_encode(fmt, op, rd, rs1, rs2, f3, f7, imm, exp_word, exp_code);
    if (model_count == cap) exp_code = 2'b11;
    in_fmt = fmt; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_func3 = f3; in_func7 = f7; in_imm = imm; in_last = last; in_valid = 1'b1;
    n = 0;
    while (!o_ready && n < 20) begin
      tick();
      n++;
    end
    if (!o_ready) begin
      check_output("ready_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    tick();
    in_valid = 1'b0;
    if (exp_code == 2'b00) begin
      check_output("wen", o_wen, 1);
      check_output("addr", o_addr, 10'(model_count % cap));
      check_output("wdata", o_wdata, exp_word);
      for (int d = 0; d < ack_delay; d++) begin
        tick();
        check_output("hold_wen", o_wen, 1);
        check_output("hold_addr", o_addr, 10'(model_count % cap));
        check_output("hold_wdata", o_wdata, exp_word);
      end
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      model_count++;
      check_output("post_wen", o_wen, 0);
      check_output("count", o_count, 11'(model_count));
      check_output("done", o_done, last);
    end else begin
      check_output("err_wen", o_wen, 0);
      check_output("err", o_err, 1);
      check_output("err_code", o_code, exp_code);
      check_output("err_count", o_count, 11'(model_count));
    end
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_ready"}, in_ready, 0);
    check_output({tag, "_wen"}, mem_wen, 0);
    check_output({tag, "_done"}, done, 0);
    check_output({tag, "_err"}, err, 0);
    check_output({tag, "_code"}, err_code, 0);
    check_output({tag, "_wdata"}, mem_wdata, 0);
    check_output({tag, "_addr"}, mem_addr, 0);
    check_output({tag, "_count"}, instr_count, 0);
  endtask

  initial begin
    logic [2:0]  r_fmt;
    logic [31:0] r_imm;
    logic [31:0] w_tmp;
    logic [1:0]  c_tmp;
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; mem_ack = 1'b0;
    in_fmt = 0; in_func3 = 0; in_opcode = 0; in_func7 = 0;
    in_rd = 0; in_rs1 = 0; in_rs2 = 0; in_imm = 0;
    #12;
    check_reset_values("reset");
    reset = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check_output("idle_ready", in_ready, 0);
    check_output("idle_wen", mem_wen, 0);

    $display("[TB] single R-type program");
    do_start();
    apply_stimulus(FMT_R, OP, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b1, 0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check_output("done_hold", done, 1);
    check_output("done_nowrite", mem_wen, 0);

    $display("[TB] ADDI/SW/BEQ with slow ack");
    do_start();
    apply_stimulus(FMT_I, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b0, 3);
    apply_stimulus(FMT_S, STORE, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 1'b0, 3);
    apply_stimulus(FMT_B, BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd4, 1'b1, 3);

    $display("[TB] LUI and JAL");
    do_start();
    apply_stimulus(FMT_U, LUI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 1'b0, 0);
    apply_stimulus(FMT_J, JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 1'b1, 1);

    $display("[TB] error cases");
    do_start();
    apply_stimulus(FMT_I, OP_IMM, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 1'b0, 0);
    do_start();
    apply_stimulus(FMT_B, BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3, 1'b0, 0);
    do_start();
    apply_stimulus(3'd7, OP, 5'd1, 5'd2, 5'd3, 3'd0, 7'd0, 32'd0, 1'b0, 0);

    $display("[TB] start beats ack and accept");
    do_start();
    in_fmt = FMT_R; in_opcode = OP; in_imm = 0; in_last = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check_output("sa_wen", mem_wen, 1);
    mem_ack = 1'b1; start = 1'b1;
    tick();
    mem_ack = 1'b0; start = 1'b0;
    check_output("sa_wen_drop", mem_wen, 0);
    check_output("sa_count", instr_count, 0);
    check_output("sa_addr", mem_addr, 0);
    in_valid = 1'b1; start = 1'b1;
    tick();
    in_valid = 1'b0; start = 1'b0;
    check_output("sv_wen", mem_wen, 0);
    check_output("sv_ready", in_ready, 1);

    $display("[TB] randomized bundles");
    do_start();
    for (int i = 0; i < 40; i++) begin
      r_fmt = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0: r_imm = $urandom;
        1: r_imm = 32'($signed($urandom_range(0, 128)) - 64);
        2: begin
          case ($urandom_range(0, 7))
            0: r_imm = 32'd2047;
            1: r_imm = 32'd2048;
            2: r_imm = -32'sd2048;
            3: r_imm = -32'sd2049;
            4: r_imm = 32'd4094;
            5: r_imm = -32'sd4096;
            6: r_imm = 32'd1048574;
            default: r_imm = -32'sd1048578;
          endcase
        end
        default: r_imm = $urandom & 32'hFFFFF000;
      endcase
      ref_encode(r_fmt, 7'($urandom), 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, r_imm, w_tmp, c_tmp);
      apply_stimulus(r_fmt, 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                     3'($urandom), 7'($urandom), r_imm, 1'b0, $urandom_range(0, 2));
      if (c_tmp != 2'b00) do_start();
    end

    $display("[TB] memory full on 4-word memory");
    use_small = 1'b1;
    do_start();
    for (int i = 0; i < 5; i++)
      apply_stimulus(FMT_I, OP_IMM, 5'(i + 1), 5'd0, 5'd0, 3'd0, 7'd0, 32'(i), 1'b0, 0);
    use_small = 1'b0;

    $display("[TB] reset during write");
    do_start();
    in_fmt = FMT_I; in_opcode = OP_IMM; in_rd = 5'd7; in_imm = 32'd9; in_last = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check_output("rw_wen", mem_wen, 1);
    #2 reset = 1'b1;
    #1;
    check_reset_values("midreset");
    #1 reset = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
